a2_regfile_write_arbiter: RTL and testbench
===========================================

A2_REGFILE_WRITE_ARBITER -- requirements
Module: a2_regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, legal range 1..15: number of consecutive WAIT cycles before stall_req asserts.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port wb_we, input, 1: pipeline writeback write enable.
REQ-005 SHALL have port wb_rd, input, 3: pipeline writeback destination register.
REQ-006 SHALL have port wb_data, input, 8: pipeline writeback data.
REQ-007 SHALL have port ld_req, input, 1: loader request; held high with stable ld_rd and ld_data until ld_gnt.
REQ-008 SHALL have port ld_rd, input, 3: loader destination register.
REQ-009 SHALL have port ld_data, input, 8: loader data.
REQ-010 SHALL have port ld_gnt, output, 1: one-cycle pulse; loader write is committed this cycle.
REQ-011 SHALL have port stall_req, output, 1: request to IF/ID to inject a bubble so a writeback slot frees up.
REQ-012 SHALL have port WriteReg, output, 1: register-file write enable.
REQ-013 SHALL have port rd, output, 3: register-file write address.
REQ-014 SHALL have port write_data, output, 8: register-file write data.

Function
REQ-015 SHALL register WriteReg, rd and write_data, so each reflects the source selected at the previous rising edge (latency 1 cycle).
REQ-016 SHALL use a 2-bit FSM with states IDLE, WAIT, STALL, DONE; ld_gnt SHALL be 1 only in DONE and stall_req SHALL be 1 only in STALL (Moore outputs).
REQ-017 Pipeline writeback SHALL have absolute priority: at any edge with wb_we=1, register WriteReg<=1, rd<=wb_rd, write_data<=wb_data.
REQ-018 Loader selection: at an edge with wb_we=0 and the FSM in IDLE/WAIT/STALL with ld_req=1, register WriteReg<=1, rd<=ld_rd, write_data<=ld_data, and next state DONE.
REQ-019 At an edge where neither source is selected, register WriteReg<=0 and hold rd and write_data.
REQ-020 IDLE transitions: ld_req=0 -> IDLE; ld_req=1 & wb_we=0 -> DONE; ld_req=1 & wb_we=1 -> WAIT with wait counter <=1.
REQ-021 WAIT transitions: ld_req=0 -> IDLE (abort, counter cleared, no write); wb_we=0 -> DONE; wb_we=1 & counter=STARVE_LIMIT -> STALL; otherwise stay in WAIT with counter +1.
REQ-022 The wait counter SHALL be 4 bits wide, saturate at 15, and be cleared on entry to IDLE or DONE.
REQ-023 STALL transitions: ld_req=0 -> IDLE; wb_we=0 -> DONE; otherwise stay in STALL (stall_req held high).
REQ-024 DONE SHALL always go to IDLE at the next edge; ld_req sampled during DONE SHALL be ignored, so one request yields exactly one grant; wb_we during DONE SHALL follow REQ-017.
REQ-025 Same-rd collision: wb write and pending loader write to the same register SHALL commit in arrival order (wb first, loader later); no merging or dropping.
REQ-026 With STARVE_LIMIT=1, stall_req SHALL assert on the second consecutive blocked cycle.

Reset
REQ-027 reset=1 at an edge SHALL force state IDLE, counter 0, WriteReg 0, rd 3'b000, write_data 8'h00, ld_gnt 0, stall_req 0, overriding all other inputs.
REQ-028 Reset mid-WAIT/STALL/DONE SHALL discard the pending loader request without a write; the loader SHALL re-request after reset deasserts.
REQ-029 The first edge after reset deasserts SHALL arbitrate normally per REQ-017..REQ-024.

Verification
REQ-030 Idle loader: wb_we=0, ld_req=1, ld_rd=3, ld_data=8'hA5 -> next cycle WriteReg=1, rd=3, write_data=8'hA5, ld_gnt=1; following cycle WriteReg=0, ld_gnt=0.
REQ-031 Contention: wb_we=1 (rd=5, data=8'h10) for 2 cycles with ld_req=1 (rd=2, data=8'h20) -> two wb writes of 8'h10, then loader write of 8'h20 to rd=2 with ld_gnt=1; stall_req stays 0.
REQ-032 Starvation: STARVE_LIMIT=4, wb_we held 1 with ld_req=1 -> stall_req rises on the 5th blocked cycle and stays high; first wb_we=0 cycle -> loader write next cycle, stall_req=0.
REQ-033 Abort: ld_req drops while in WAIT -> IDLE, no loader write, ld_gnt never asserts, counter 0.
REQ-034 Reset in STALL: assert reset one cycle -> all outputs 0 / 8'h00, state IDLE; no loader write after release until a new ld_req.
REQ-035 Held request: ld_req kept high through DONE -> exactly one ld_gnt pulse per DONE; a second grant only after passing through IDLE.

Source files
------------

// File: rtl/a2_regfile_write_arbiter_if.sv
// Register-file write port bundle: pipeline writeback, loader handshake and
// the single registered write port into the register file.
interface a2_regfile_write_arbiter_if;
  logic       wb_we;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       ld_req;
  logic [2:0] ld_rd;
  logic [7:0] ld_data;
  logic       ld_gnt;
  logic       stall_req;
  logic       WriteReg;
  logic [2:0] rd;
  logic [7:0] write_data;

  modport master (
    output wb_we, wb_rd, wb_data, ld_req, ld_rd, ld_data,
    input  ld_gnt, stall_req, WriteReg, rd, write_data
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, ld_req, ld_rd, ld_data,
    output ld_gnt, stall_req, WriteReg, rd, write_data
  );
endinterface

// File: rtl/a2_regfile_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// (absolute priority) and a loader; starved loader requests raise stall_req.
module a2_regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                        clk,
  input logic                        reset,
  a2_regfile_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic [3:0] wait_cnt_r;
  logic       write_reg_r;
  logic [2:0] rd_r;
  logic [7:0] write_data_r;
  logic       ld_gnt_r;
  logic       stall_req_r;
  logic       ld_sel_s;
  logic       at_limit_s;
  logic [3:0] wait_cnt_inc_s;

  // A request seen while in DONE already received its grant, so it is ignored.
  assign ld_sel_s       = bus.ld_req && !bus.wb_we && (state_r != DONE);
  assign at_limit_s     = (wait_cnt_r == 4'(STARVE_LIMIT));
  assign wait_cnt_inc_s = (wait_cnt_r == 4'hF) ? 4'hF : (wait_cnt_r + 4'd1);

  assign bus.WriteReg   = write_reg_r;
  assign bus.rd         = rd_r;
  assign bus.write_data = write_data_r;
  assign bus.ld_gnt     = ld_gnt_r;
  assign bus.stall_req  = stall_req_r;

  // Write-port datapath and arbitration FSM with registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      wait_cnt_r   <= 4'd0;
      write_reg_r  <= 1'b0;
      rd_r         <= 3'b000;
      write_data_r <= 8'h00;
      ld_gnt_r     <= 1'b0;
      stall_req_r  <= 1'b0;
    end else begin
      if (bus.wb_we) begin
        write_reg_r  <= 1'b1;
        rd_r         <= bus.wb_rd;
        write_data_r <= bus.wb_data;
      end else if (ld_sel_s) begin
        write_reg_r  <= 1'b1;
        rd_r         <= bus.ld_rd;
        write_data_r <= bus.ld_data;
      end else begin
        write_reg_r  <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (!bus.ld_req) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            ld_gnt_r    <= 1'b0;
            stall_req_r <= 1'b0;
          end else if (!bus.wb_we) begin
            state_r     <= DONE;
            wait_cnt_r  <= 4'd0;
            ld_gnt_r    <= 1'b1;
            stall_req_r <= 1'b0;
          end else begin
            state_r     <= WAIT;
            wait_cnt_r  <= 4'd1;
            ld_gnt_r    <= 1'b0;
            stall_req_r <= 1'b0;
          end
        end
        WAIT: begin
          if (!bus.ld_req) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            ld_gnt_r    <= 1'b0;
            stall_req_r <= 1'b0;
          end else if (!bus.wb_we) begin
            state_r     <= DONE;
            wait_cnt_r  <= 4'd0;
            ld_gnt_r    <= 1'b1;
            stall_req_r <= 1'b0;
          end else if (at_limit_s) begin
            state_r     <= STALL;
            wait_cnt_r  <= wait_cnt_r;
            ld_gnt_r    <= 1'b0;
            stall_req_r <= 1'b1;
          end else begin
            state_r     <= WAIT;
            wait_cnt_r  <= wait_cnt_inc_s;
            ld_gnt_r    <= 1'b0;
            stall_req_r <= 1'b0;
          end
        end
        STALL: begin
          if (!bus.ld_req) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            ld_gnt_r    <= 1'b0;
            stall_req_r <= 1'b0;
          end else if (!bus.wb_we) begin
            state_r     <= DONE;
            wait_cnt_r  <= 4'd0;
            ld_gnt_r    <= 1'b1;
            stall_req_r <= 1'b0;
          end else begin
            state_r     <= STALL;
            wait_cnt_r  <= wait_cnt_r;
            ld_gnt_r    <= 1'b0;
            stall_req_r <= 1'b1;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          wait_cnt_r  <= 4'd0;
          ld_gnt_r    <= 1'b0;
          stall_req_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          wait_cnt_r  <= 4'd0;
          ld_gnt_r    <= 1'b0;
          stall_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a2_regfile_write_arbiter.sv
// Directed bench for the register-file write arbiter, run with STARVE_LIMIT 4
// and 1 side by side against a request-level reference model.
module tb_a2_regfile_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   model_valid = 1'b0;

  always #5 clk = ~clk;

  a2_regfile_write_arbiter_if bus4 ();
  a2_regfile_write_arbiter_if bus1 ();

  assign bus1.wb_we   = bus4.wb_we;
  assign bus1.wb_rd   = bus4.wb_rd;
  assign bus1.wb_data = bus4.wb_data;
  assign bus1.ld_req  = bus4.ld_req;
  assign bus1.ld_rd   = bus4.ld_rd;
  assign bus1.ld_data = bus4.ld_data;

  a2_regfile_write_arbiter #(.STARVE_LIMIT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  a2_regfile_write_arbiter #(.STARVE_LIMIT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Model state: gl = the request was granted at the previous edge,
  // blk = consecutive edges the current request lost to writeback.
  typedef struct {
    bit         gl;
    int         blk;
    bit         we;
    logic [2:0] rd;
    logic [7:0] data;
    bit         gnt;
    bit         stall;
  } mstate_t;

  mstate_t m4, m1;

  function automatic mstate_t model_step(mstate_t s, int lim, bit rst, bit wbwe,
                                         logic [2:0] wbrd, logic [7:0] wbd,
                                         bit lreq, logic [2:0] lrd, logic [7:0] ldd);
    mstate_t r;
    bit grant;
    r = s;
    if (rst) begin
      r.gl = 1'b0; r.blk = 0; r.we = 1'b0; r.rd = 3'd0; r.data = 8'h00;
      r.gnt = 1'b0; r.stall = 1'b0;
      return r;
    end
    grant = lreq && !wbwe && !s.gl;
    if (wbwe) begin
      r.we = 1'b1; r.rd = wbrd; r.data = wbd;
    end else if (grant) begin
      r.we = 1'b1; r.rd = lrd; r.data = ldd;
    end else begin
      r.we = 1'b0;
    end
    r.blk   = (lreq && wbwe && !s.gl) ? ((s.blk < 1000) ? s.blk + 1 : s.blk) : 0;
    r.stall = (r.blk > lim);
    r.gnt   = grant;
    r.gl    = grant;
    return r;
  endfunction

  always @(posedge clk) begin
    m4 <= model_step(m4, 4, reset, bus4.wb_we, bus4.wb_rd, bus4.wb_data,
                     bus4.ld_req, bus4.ld_rd, bus4.ld_data);
    m1 <= model_step(m1, 1, reset, bus4.wb_we, bus4.wb_rd, bus4.wb_data,
                     bus4.ld_req, bus4.ld_rd, bus4.ld_data);
    model_valid <= model_valid | reset;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m4_we",    {7'd0, bus4.WriteReg},  {7'd0, m4.we});
      chk("m4_rd",    {5'd0, bus4.rd},        {5'd0, m4.rd});
      chk("m4_data",  bus4.write_data,        m4.data);
      chk("m4_gnt",   {7'd0, bus4.ld_gnt},    {7'd0, m4.gnt});
      chk("m4_stall", {7'd0, bus4.stall_req}, {7'd0, m4.stall});
      chk("m1_we",    {7'd0, bus1.WriteReg},  {7'd0, m1.we});
      chk("m1_rd",    {5'd0, bus1.rd},        {5'd0, m1.rd});
      chk("m1_data",  bus1.write_data,        m1.data);
      chk("m1_gnt",   {7'd0, bus1.ld_gnt},    {7'd0, m1.gnt});
      chk("m1_stall", {7'd0, bus1.stall_req}, {7'd0, m1.stall});
    end
  end

  task automatic cyc(input logic rst, input logic we, input logic [2:0] wrd,
                     input logic [7:0] wd, input logic lr, input logic [2:0] lrd,
                     input logic [7:0] ldd);
    reset        = rst;
    bus4.wb_we   = we;
    bus4.wb_rd   = wrd;
    bus4.wb_data = wd;
    bus4.ld_req  = lr;
    bus4.ld_rd   = lrd;
    bus4.ld_data = ldd;
    @(posedge clk);
    #2;
  endtask

  task automatic out4(input string nm, input logic we, input logic [2:0] r,
                      input logic [7:0] d, input logic g, input logic s);
    chk({nm, "_we"},    {7'd0, bus4.WriteReg},  {7'd0, we});
    chk({nm, "_rd"},    {5'd0, bus4.rd},        {5'd0, r});
    chk({nm, "_data"},  bus4.write_data,        d);
    chk({nm, "_gnt"},   {7'd0, bus4.ld_gnt},    {7'd0, g});
    chk({nm, "_stall"}, {7'd0, bus4.stall_req}, {7'd0, s});
  endtask

  initial begin
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc(1'b1, 1'b1, 3'd7, 8'hFF, 1'b1, 3'd6, 8'hEE);
    out4("reset", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);

    // Idle loader grant, then quiet cycle holding address and data.
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'hA5);
    out4("idle_ld", 1'b1, 3'd3, 8'hA5, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 8'hA5);
    out4("idle_after", 1'b0, 3'd3, 8'hA5, 1'b0, 1'b0);

    // Two-cycle contention, writeback wins then loader commits.
    cyc(1'b0, 1'b1, 3'd5, 8'h10, 1'b1, 3'd2, 8'h20);
    out4("cont_wb1", 1'b1, 3'd5, 8'h10, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'd5, 8'h10, 1'b1, 3'd2, 8'h20);
    out4("cont_wb2", 1'b1, 3'd5, 8'h10, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd5, 8'h10, 1'b1, 3'd2, 8'h20);
    out4("cont_ld", 1'b1, 3'd2, 8'h20, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

    // Starvation: limit 4 stalls on the 5th blocked edge, limit 1 on the 2nd.
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b1, 3'd1, 8'(i), 1'b1, 3'd4, 8'h44);
      if (i == 1) chk("starve1_c1", {7'd0, bus1.stall_req}, 8'd0);
      if (i == 2) chk("starve1_c2", {7'd0, bus1.stall_req}, 8'd1);
      if (i == 4) chk("starve4_c4", {7'd0, bus4.stall_req}, 8'd0);
      if (i == 5) chk("starve4_c5", {7'd0, bus4.stall_req}, 8'd1);
      if (i == 6) chk("starve4_c6", {7'd0, bus4.stall_req}, 8'd1);
    end
    cyc(1'b0, 1'b0, 3'd1, 8'h06, 1'b1, 3'd4, 8'h44);
    out4("starve_rel", 1'b1, 3'd4, 8'h44, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

    // Abort while waiting: no grant ever appears.
    cyc(1'b0, 1'b1, 3'd2, 8'h31, 1'b1, 3'd5, 8'h55);
    cyc(1'b0, 1'b1, 3'd2, 8'h32, 1'b1, 3'd5, 8'h55);
    cyc(1'b0, 1'b1, 3'd2, 8'h33, 1'b0, 3'd5, 8'h55);
    out4("abort", 1'b1, 3'd2, 8'h33, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 8'h55);
    out4("abort_idle", 1'b0, 3'd2, 8'h33, 1'b0, 1'b0);

    // Reset while stalled discards the request.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 3'd1, 8'h60, 1'b1, 3'd6, 8'h66);
    chk("pre_rst_stall", {7'd0, bus4.stall_req}, 8'd1);
    cyc(1'b1, 1'b1, 3'd1, 8'h60, 1'b1, 3'd6, 8'h66);
    out4("rst_stall", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 8'h66);
    out4("post_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66);
    out4("rereq", 1'b1, 3'd6, 8'h66, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

    // Held request: one grant per pass through IDLE.
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h77);
    out4("held_g1", 1'b1, 3'd7, 8'h77, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h77);
    out4("held_done", 1'b0, 3'd7, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h78);
    out4("held_g2", 1'b1, 3'd7, 8'h78, 1'b1, 1'b0);
    // Writeback during DONE still commits.
    cyc(1'b0, 1'b1, 3'd3, 8'h99, 1'b1, 3'd7, 8'h78);
    out4("wb_in_done", 1'b1, 3'd3, 8'h99, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

    // Same-register collision commits writeback first, then loader.
    cyc(1'b0, 1'b1, 3'd6, 8'hC6, 1'b1, 3'd6, 8'hD7);
    out4("same_wb", 1'b1, 3'd6, 8'hC6, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hD7);
    out4("same_ld", 1'b1, 3'd6, 8'hD7, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

    // Patterned mixed traffic checked by the model alone.
    for (int i = 0; i < 80; i++) begin
      cyc(1'b0, ((i * 5) % 7) < 4, 3'(i), 8'(i * 3), (i % 11) != 0,
          3'(i / 5), 8'(8'hB0 + 8'(i / 5)));
    end
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
